// File: rtl/spu_pkg.sv
// rtl/spu_pkg.sv - shared FSM states, record layout and no-data code for the zonal stats block
package spu_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ACCUM = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

  localparam int REC_LEN = 5;
  localparam int REC_W   = 8 * REC_LEN;

  localparam logic [2:0] B0 = 3'd0;
  localparam logic [2:0] B1 = 3'd1;
  localparam logic [2:0] B2 = 3'd2;
  localparam logic [2:0] B3 = 3'd3;
  localparam logic [2:0] B4 = 3'd4;

  localparam logic [3:0] NODATA = 4'd0;

endpackage

// File: rtl/ndi_zstat_serializer.sv
// rtl/ndi_zstat_serializer.sv - latches a finished record and drains it one byte per handshake
module ndi_zstat_serializer
  import spu_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [REC_W-1:0] record,
  input  logic             out_ready,
  output logic             out_valid,
  output logic [7:0]       out_data,
  output logic             out_last,
  output logic             done
);

  logic [REC_W-1:0] rec;
  logic [2:0]       byte_idx;
  logic             hs;

  assign hs   = out_valid & out_ready;
  assign done = hs & (byte_idx == B4);

  // Record latch and byte pointer; the pointer only moves on a consumed byte.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rec       <= '0;
      byte_idx  <= B0;
      out_valid <= 1'b0;
    end else if (load) begin
      rec       <= record;
      byte_idx  <= B0;
      out_valid <= 1'b1;
    end else if (hs) begin
      if (byte_idx == B4) begin
        rec       <= '0;
        byte_idx  <= B0;
        out_valid <= 1'b0;
      end else begin
        byte_idx <= byte_idx + 3'd1;
      end
    end
  end

  // Byte mux; forced to zero whenever nothing is being presented.
  always_comb begin
    out_data = 8'h00;
    out_last = 1'b0;
    if (out_valid) begin
      case (byte_idx)
        B0:      out_data = rec[7:0];
        B1:      out_data = rec[15:8];
        B2:      out_data = rec[23:16];
        B3:      out_data = rec[31:24];
        B4:      out_data = rec[39:32];
        default: out_data = 8'h00;
      endcase
      out_last = (byte_idx == B4);
    end
  end

endmodule

// File: rtl/ndi_zonal_stats.sv
// rtl/ndi_zonal_stats.sv - per-frame index statistics with 5-byte record output (option: NDI_ZSTAT_NODATA_SKIP_EN)
module ndi_zonal_stats
  import spu_pkg::*;
#(
  parameter int CNT_W = 8,
  parameter int SUM_W = 12
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic       in_last,
  input  logic [3:0] in_m,
  input  logic [3:0] in_n,
  input  logic [3:0] thresh,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [7:0] out_data,
  output logic       out_last
);

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt, above, cnt_nxt, above_nxt;
  logic [SUM_W-1:0] sum, sum_nxt;
  logic [3:0]       mn, mx, thr, mn_nxt, mx_nxt, thr_eff;
  logic             accept, load, rec_done, va, vb;
  logic [1:0]       n_valid, n_above;
  logic [4:0]       sum_add;
  logic [CNT_W+1:0] cnt_wide, above_wide;
  logic [SUM_W:0]   sum_wide;
  logic [15:0]      sum16;
  logic [7:0]       b4;
  logic [REC_W-1:0] record;

  assign in_ready = (state != ST_DRAIN);
  assign accept   = in_valid & in_ready;

  // Next accumulator values for the beat on the inputs, saturating at all-ones.
  always_comb begin
    thr_eff = (state == ST_IDLE) ? thresh : thr;
`ifdef NDI_ZSTAT_NODATA_SKIP_EN
    va = (in_m != NODATA);
    vb = (in_n != NODATA);
`else
    va = 1'b1;
    vb = 1'b1;
`endif
    n_valid    = {1'b0, va} + {1'b0, vb};
    n_above    = {1'b0, va && (in_m >= thr_eff)} + {1'b0, vb && (in_n >= thr_eff)};
    sum_add    = {1'b0, va ? in_m : 4'd0} + {1'b0, vb ? in_n : 4'd0};
    cnt_wide   = {2'b00, cnt} + {{CNT_W{1'b0}}, n_valid};
    above_wide = {2'b00, above} + {{CNT_W{1'b0}}, n_above};
    sum_wide   = {1'b0, sum} + {{(SUM_W-4){1'b0}}, sum_add};
    cnt_nxt    = (|cnt_wide[CNT_W+1:CNT_W]) ? '1 : cnt_wide[CNT_W-1:0];
    above_nxt  = (|above_wide[CNT_W+1:CNT_W]) ? '1 : above_wide[CNT_W-1:0];
    sum_nxt    = sum_wide[SUM_W] ? '1 : sum_wide[SUM_W-1:0];
    mn_nxt     = mn;
    mx_nxt     = mx;
    if (va && (in_m < mn_nxt)) mn_nxt = in_m;
    if (vb && (in_n < mn_nxt)) mn_nxt = in_n;
    if (va && (in_m > mx_nxt)) mx_nxt = in_m;
    if (vb && (in_n > mx_nxt)) mx_nxt = in_n;
    sum16 = 16'(sum_nxt);
`ifdef NDI_ZSTAT_NODATA_SKIP_EN
    b4 = (cnt_nxt == '0) ? 8'h00 : {mx_nxt, mn_nxt};
`else
    b4 = {mx_nxt, mn_nxt};
`endif
    record = {b4, sum16[15:8], sum16[7:0], 8'(above_nxt), 8'(cnt_nxt)};
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  // Frame sequencing; the final beat hands the record to the serializer.
  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    case (state)
      ST_IDLE: begin
        if (accept) begin
          load      = in_last;
          state_nxt = in_last ? ST_DRAIN : ST_ACCUM;
        end
      end
      ST_ACCUM: begin
        if (accept && in_last) begin
          load      = 1'b1;
          state_nxt = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (rec_done) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Accumulators: update on every accepted beat, clear once the record is gone.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0; above <= '0; sum <= '0; mn <= 4'd15; mx <= 4'd0; thr <= 4'd0;
    end else if (rec_done) begin
      cnt <= '0; above <= '0; sum <= '0; mn <= 4'd15; mx <= 4'd0; thr <= 4'd0;
    end else if (accept) begin
      cnt   <= cnt_nxt;
      above <= above_nxt;
      sum   <= sum_nxt;
      mn    <= mn_nxt;
      mx    <= mx_nxt;
      if (state == ST_IDLE) thr <= thresh;
    end
  end

  ndi_zstat_serializer u_ser (
    .clk       (clk),
    .rst       (rst),
    .load      (load),
    .record    (record),
    .out_ready (out_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_last  (out_last),
    .done      (rec_done)
  );

endmodule
